fifo_push_arbiter: RTL and testbench
====================================

Name: fifo_push_arbiter

Overview:
Round-robin arbiter that shares the single push port of the 2-bit FiFo between N_REQ producers.
- Per-producer valid/ready handshake; each accepted beat is forwarded as one fifo push, tagged with the source index so the consumer can demultiplex.
- Optional burst lock lets a winner keep the port for up to MAX_BURST consecutive beats.
- Sits directly in front of the FiFo instance; the consumer drives pop independently.

Parameters:
- N_REQ, 4, number of producers (any value >= 2, power of two not required)
- DATA_W, 2, producer payload width (matches FiFo data width minus tag)
- MAX_BURST, 2, max beats per grant (1 = pure per-beat round robin, never locks)
- TAG_W, derived localparam = clog2(N_REQ), not overridable

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- req_valid  in  N_REQ  producer i has a beat
- req_data  in  N_REQ*DATA_W  producer i payload at [i*DATA_W +: DATA_W]
- req_ready  out  N_REQ  one-hot or zero; beat i accepted this cycle when req_valid[i] & req_ready[i]
- fifo_push  out  1  to FiFo push
- fifo_din  out  TAG_W+DATA_W  to FiFo din = {tag, payload}
- fifo_full  in  1  from FiFo full
- grant_id  out  TAG_W  current winner index, meaningful only when fifo_push=1
- busy  out  1  1 while in BURST (port locked to an owner)

Behaviour:
- State: st (IDLE/BURST), rr_ptr[TAG_W], owner[TAG_W], cnt (counts 1..MAX_BURST).
- Reset low: st=IDLE, rr_ptr=0, owner=0, cnt=0 asynchronously. req_ready=0, fifo_push=0, busy=0 are forced combinationally while reset is low.
- fifo_push = |(req_valid & req_ready). Latency 0: the push happens in the same cycle as the handshake. req_ready never asserts while fifo_full=1.
- IDLE:
  - winner = first i with req_valid[i], scanning circularly from rr_ptr.
  - If any valid and !fifo_full: req_ready[winner]=1, push. rr_ptr <= (winner+1) mod N_REQ, wrapping N_REQ-1 -> 0.
  - On that push, if MAX_BURST>1: st<=BURST, owner<=winner, cnt<=1.
  - If fifo_full: no push, nothing latched; re-arbitrate next cycle.
- BURST: only owner is eligible; other requesters see ready=0.
  - owner valid & !full: push, cnt<=cnt+1. If cnt+1==MAX_BURST, st<=IDLE.
  - owner valid & full: stall. No push; st and cnt hold.
  - owner !valid: release. No push this cycle (one bubble), st<=IDLE; rr_ptr unchanged (already past owner).
- fifo_din = {grant_id, payload of winner/owner}; value is don't-care when push=0 but must not be X (drive 0).
- busy = (st==BURST), registered.
- Producers may drop req_valid at any time; the arbiter never assumes stickiness.

Decomposition:
- Shared include fifo_arb_defs.vh: state encodings ST_IDLE=1'b0, ST_BURST=1'b1; clog2 constant function.
- One combinational sub-module rr_pick (valid vector, ptr -> winner index, any_valid). Reused by future pop-side schedulers.

Test Plan:
- Reset: hold reset=0 with all req_valid=1 -> req_ready=0000, fifo_push=0, busy=0. Release with req_valid=0 -> push stays 0.
- Single producer, MAX_BURST=2: req_valid=0100, req_data[2]=3, full=0 -> cycle 1 push, din={2'd2,2'd3}, ready=0100; busy=1 next cycle; cycle 2 second push; then busy=0, next winner search starts at 3.
- Fairness, MAX_BURST=1: req_valid=1111 held, full=0 -> grant_id sequence 0,1,2,3,0 on consecutive cycles; busy never 1.
- Full stall mid-burst, MAX_BURST=2: producer 1 wins beat 1; full=1 for 2 cycles with req_valid=0011 -> push=0, ready=0000, busy=1. Full drops -> producer 1 pushes beat 2 (not 0), then IDLE; next grant goes to 0 (wrap past 2,3 idle).
- Owner drops valid: burst owner 0 deasserts after beat 1, req_valid=0010 -> one cycle push=0, busy=0 next, then producer 1 granted.
- Async reset mid-burst: assert reset=0 between edges while busy=1 -> busy=0 and push=0 immediately. After release with req_valid=1111, producer 0 wins first.

Source files
------------

// File: rtl/fifo_push_arbiter_pkg.sv
// Shared definitions for the FiFo push-side arbiter and pickers.
// Holds the state encoding and a constant clog2 helper.
package fifo_push_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Never returns 0, so derived widths stay legal even for n <= 2.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Combinational circular priority picker: the first set bit of valid,
// scanning upward from ptr and wrapping past N-1 back to 0.
module rr_pick #(
    parameter int N     = 4,
    parameter int TAG_W = 2
) (
    input  logic [N-1:0]     valid,
    input  logic [TAG_W-1:0] ptr,
    output logic [TAG_W-1:0] winner,
    output logic             any_valid
);

    always_comb begin
        int idx;
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!any_valid && valid[idx]) begin
                any_valid = 1'b1;
                winner    = TAG_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter that shares one FiFo push port among N_REQ producers.
// The grant is combinational (push in the handshake cycle); an optional burst lock holds the port.
module fifo_push_arbiter
    import fifo_push_arbiter_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int DATA_W    = 2,
    parameter  int MAX_BURST = 2,
    localparam int TAG_W     = clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    fifo_push,
    output logic [TAG_W+DATA_W-1:0] fifo_din,
    input  logic                    fifo_full,
    output logic [TAG_W-1:0]        grant_id,
    output logic                    busy
);

    localparam int CNT_W = clog2(MAX_BURST + 1);

    arb_state_e       st_q, st_d;
    logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [TAG_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [TAG_W-1:0] winner;
    logic             any_valid;
    logic [N_REQ-1:0] ready_c;
    logic [TAG_W-1:0] gid_c;
    logic [DATA_W-1:0] payload;

    rr_pick #(.N(N_REQ), .TAG_W(TAG_W)) u_pick (
        .valid     (req_valid),
        .ptr       (rr_ptr_q),
        .winner    (winner),
        .any_valid (any_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q     <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
        end else begin
            st_q     <= st_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        st_d     = st_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        ready_c  = '0;
        gid_c    = '0;
        case (st_q)
            ST_IDLE: begin
                gid_c = winner;
                if (any_valid && !fifo_full) begin
                    ready_c[winner] = 1'b1;
                    rr_ptr_d = (winner == TAG_W'(N_REQ - 1)) ? '0 : winner + TAG_W'(1);
                    if (MAX_BURST > 1) begin
                        st_d    = ST_BURST;
                        owner_d = winner;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_BURST: begin
                gid_c = owner_q;
                if (req_valid[owner_q]) begin
                    if (!fifo_full) begin
                        ready_c[owner_q] = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q + CNT_W'(1) == CNT_W'(MAX_BURST)) st_d = ST_IDLE;
                    end
                end else begin
                    // Owner went away: give up the lock; rr_ptr already points past it.
                    st_d = ST_IDLE;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    assign payload   = req_data[int'(gid_c)*DATA_W +: DATA_W];
    assign req_ready = reset ? ready_c : '0;
    assign fifo_push = |(req_valid & req_ready);
    assign fifo_din  = fifo_push ? {gid_c, payload} : '0;
    assign grant_id  = gid_c;
    assign busy      = reset && (st_q == ST_BURST);

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench: dut2 locks bursts of two beats, dut1 does pure per-beat round robin.
module tb_fifo_push_arbiter;

    logic       clk;
    logic       reset;

    logic [3:0] v2, rdy2;
    logic [7:0] d2;
    logic       full2, push2, busy2;
    logic [3:0] din2;
    logic [1:0] gid2;

    logic [3:0] v1, rdy1;
    logic [7:0] d1;
    logic       full1, push1, busy1;
    logic [3:0] din1;
    logic [1:0] gid1;

    int n_vec;
    int n_err;

    fifo_push_arbiter #(.N_REQ(4), .DATA_W(2), .MAX_BURST(2)) dut2 (
        .clk(clk), .reset(reset), .req_valid(v2), .req_data(d2), .req_ready(rdy2),
        .fifo_push(push2), .fifo_din(din2), .fifo_full(full2), .grant_id(gid2), .busy(busy2)
    );

    fifo_push_arbiter #(.N_REQ(4), .DATA_W(2), .MAX_BURST(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(v1), .req_data(d1), .req_ready(rdy1),
        .fifo_push(push1), .fifo_din(din1), .fifo_full(full1), .grant_id(gid1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        v2 = 4'b1111; d2 = 8'h00; full2 = 1'b0;
        v1 = 4'b1111; d1 = 8'hE4; full1 = 1'b0;

        // reset held with every producer requesting
        settle();
        check("rst_ready", 32'(rdy2), 32'h0);
        check("rst_push", 32'(push2), 32'h0);
        check("rst_busy", 32'(busy2), 32'h0);
        check("rst_ready1", 32'(rdy1), 32'h0);
        tick();
        v2 = 4'b0000; v1 = 4'b0000;
        reset = 1'b1;
        settle();
        check("rel_push", 32'(push2), 32'h0);
        check("rel_busy", 32'(busy2), 32'h0);
        tick();

        // single producer 2, two-beat burst
        v2 = 4'b0100; d2 = 8'h30;
        settle();
        check("sp_push1", 32'(push2), 32'h1);
        check("sp_din1", 32'(din2), 32'hB);
        check("sp_ready1", 32'(rdy2), 32'h4);
        check("sp_gid1", 32'(gid2), 32'h2);
        tick();
        check("sp_busy", 32'(busy2), 32'h1);
        check("sp_push2", 32'(push2), 32'h1);
        check("sp_din2", 32'(din2), 32'hB);
        tick();
        check("sp_idle", 32'(busy2), 32'h0);
        v2 = 4'b1001; d2 = 8'h00;
        settle();
        check("sp_next_gid", 32'(gid2), 32'h3);
        check("sp_next_ready", 32'(rdy2), 32'h8);
        tick();
        v2 = 4'b0000;
        settle();
        check("sp_drop_push", 32'(push2), 32'h0);
        tick();
        check("sp_drop_busy", 32'(busy2), 32'h0);

        // full blocks ready in IDLE
        v2 = 4'b0001; full2 = 1'b1;
        settle();
        check("idle_full_ready", 32'(rdy2), 32'h0);
        check("idle_full_push", 32'(push2), 32'h0);
        tick();
        check("idle_full_busy", 32'(busy2), 32'h0);

        // full stall mid-burst, producer 1 owns the port
        full2 = 1'b0; v2 = 4'b0010; d2 = 8'h08;
        settle();
        check("st_gid1", 32'(gid2), 32'h1);
        check("st_din1", 32'(din2), 32'h6);
        tick();
        v2 = 4'b0011; full2 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            settle();
            check("st_stall_push", 32'(push2), 32'h0);
            check("st_stall_ready", 32'(rdy2), 32'h0);
            check("st_stall_busy", 32'(busy2), 32'h1);
            tick();
        end
        full2 = 1'b0;
        settle();
        check("st_beat2_push", 32'(push2), 32'h1);
        check("st_beat2_gid", 32'(gid2), 32'h1);
        check("st_beat2_ready", 32'(rdy2), 32'h2);
        tick();
        settle();
        check("st_after_busy", 32'(busy2), 32'h0);
        check("st_wrap_gid", 32'(gid2), 32'h0);
        check("st_wrap_ready", 32'(rdy2), 32'h1);
        tick();

        // burst owner 0 drops valid after beat 1
        check("od_busy", 32'(busy2), 32'h1);
        v2 = 4'b0010;
        settle();
        check("od_bubble_push", 32'(push2), 32'h0);
        check("od_bubble_ready", 32'(rdy2), 32'h0);
        tick();
        check("od_busy_after", 32'(busy2), 32'h0);
        check("od_gid", 32'(gid2), 32'h1);
        check("od_push", 32'(push2), 32'h1);
        tick();

        // async reset between edges while a burst is active
        check("ar_busy_before", 32'(busy2), 32'h1);
        #2;
        reset = 1'b0;
        v2 = 4'b1111;
        #1;
        check("ar_busy", 32'(busy2), 32'h0);
        check("ar_push", 32'(push2), 32'h0);
        check("ar_ready", 32'(rdy2), 32'h0);
        #1;
        reset = 1'b1;
        #1;
        check("ar_first_gid", 32'(gid2), 32'h0);
        check("ar_first_push", 32'(push2), 32'h1);
        check("ar_first_ready", 32'(rdy2), 32'h1);
        tick();
        v2 = 4'b0000;

        // pure round robin on dut1, payload i for producer i
        v1 = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [1:0] e;
            e = 2'(k % 4);
            settle();
            check("rr_gid", 32'(gid1), 32'(e));
            check("rr_din", 32'(din1), 32'({e, e}));
            check("rr_busy", 32'(busy1), 32'h0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
